muldiv_controller: RTL and testbench
====================================

Name: muldiv_controller

Overview:
- Sequencer between the multicycle control unit and the shared multiplier and divider units.
- Accepts one HI/LO operation at a time and latches its operands.
- Pulses the selected unit's start line, waits for that unit's done, then commits its results into the architectural HI/LO registers.
- Holds Busy high so the control unit stalls, and flags divide-by-zero and unit timeout.

Parameters:
TIMEOUT, 48, max WAIT cycles before the unit is declared hung (must be ≥ 2).

Ports:
Clock  in  1  system clock; all state updates on posedge.
Reset  in  1  reset; synchronous, active-high.
Start  in  1  request from the control unit; sampled only in IDLE.
Op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
A  in  32  rs operand.
B  in  32  rt operand.
MultStart  out  1  one-cycle start pulse to the multiplier (its CtoM).
MultA  out  32  latched A, held stable while the multiplier runs.
MultB  out  32  latched B, held stable while the multiplier runs.
MultDone  in  1  multiplier done (its MtoC).
MultHigh  in  32  multiplier result, high word.
MultLow  in  32  multiplier result, low word.
DivStart  out  1  one-cycle start pulse to the divider.
DivA  out  32  latched dividend.
DivB  out  32  latched divisor.
DivDone  in  1  divider done.
DivHigh  in  32  remainder.
DivLow  in  32  quotient.
Busy  out  1  high in every state except IDLE.
Done  out  1  one-cycle pulse; HI/LO are updated and valid in this cycle.
DivZero  out  1  one-cycle pulse on DIV with B == 0.
Timeout  out  1  one-cycle pulse when the unit does not answer in time.
HI  out  32  architectural HI register.
LO  out  32  architectural LO register.

Behaviour:
- Reset:
  - State goes to IDLE.
  - HI, LO, MultA/B and DivA/B clear to 0.
  - MultStart, DivStart, Busy, Done, DivZero and Timeout all go to 0.
  - Reset mid-operation abandons the operation; any later unit done is ignored.
- States: IDLE, LAUNCH, WAIT, COMMIT, FAULT.
- IDLE, Start=1:
  - Op=10 (MTHI): HI<=A at this edge; Done pulses next cycle; state stays IDLE. Busy stays 0 throughout.
  - Op=11 (MTLO): LO<=A at this edge; Done pulses next cycle; state stays IDLE. Busy stays 0 throughout.
  - Op=01 with B==0: no launch; go to FAULT with DivZero=1; HI/LO unchanged.
  - Op=00, or Op=01 with B≠0: latch A/B into the selected unit's operand outputs, store the unit select, go to LAUNCH.
- Start while not in IDLE is ignored; the control unit must hold Start until Busy falls.
- LAUNCH, exactly one cycle:
  - Assert MultStart or DivStart, never both.
  - Clear the wait counter.
  - Go to WAIT.
- WAIT:
  - Watch only the selected unit's done signal; the other unit's done is ignored.
  - Done sampled high: capture High→HI and Low→LO at that edge, go to COMMIT.
  - Otherwise increment the wait counter.
  - Counter == TIMEOUT−1 with no done: go to FAULT with Timeout=1; HI/LO unchanged.
- COMMIT: Done=1 for one cycle, then go to IDLE.
- FAULT: DivZero or Timeout=1 for one cycle, then go to IDLE.
- Latency:
  - Start accepted at edge 0, start pulse in cycle 1, WAIT from cycle 2.
  - Unit done sampled at edge k → HI/LO updated at edge k, Done high in cycle k+1, Busy low from cycle k+2.
- Start pulses are never held for more than one cycle; a unit done high on entry to WAIT (stale) is accepted.
- HI/LO change only through COMMIT or MTHI/MTLO.
- No arithmetic is done in this block; MULTU/DIVU are out of scope.

Test Plan:
- Reset, then MULT A=7, B=0xFFFFFFFD, unit model answers 33 cycles after MultStart with HI=0xFFFFFFFF, LO=0xFFFFFFEB → MultStart is a single 1-cycle pulse; Done pulses once; HI/LO match; Busy drops the cycle after Done.
- DIV A=100, B=7, model answers with quotient 14, remainder 2 → LO=14, HI=2; MultStart never asserted.
- DIV A=5, B=0 → DivZero pulses at cycle 1; no DivStart; HI/LO keep their prior values; Busy high for exactly one cycle.
- MULT with the model never answering, TIMEOUT=48 → Timeout pulses; HI/LO unchanged; a late MultDone after returning to IDLE is ignored.
- MTHI A=0xDEADBEEF then MTLO A=0x12345678 on back-to-back cycles → HI/LO hold those values; Busy stays 0; Done pulses twice.
- Start MULT, assert Reset in WAIT, then the model raises MultDone → state IDLE, HI=LO=0, no Done; a second Start issued during Busy is never launched.

Source files
------------

// File: rtl/muldiv_controller.sv
// HI/LO sequencer between the multicycle control unit and the shared multiplier/divider.
// Latches operands, pulses the selected unit, waits for its done and commits High/Low to HI/LO.
module muldiv_controller #(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        MultStart,
    output logic [31:0] MultA,
    output logic [31:0] MultB,
    input  logic        MultDone,
    input  logic [31:0] MultHigh,
    input  logic [31:0] MultLow,
    output logic        DivStart,
    output logic [31:0] DivA,
    output logic [31:0] DivB,
    input  logic        DivDone,
    input  logic [31:0] DivHigh,
    input  logic [31:0] DivLow,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic        Timeout,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

    localparam logic [1:0] OpMult = 2'b00;
    localparam logic [1:0] OpDiv  = 2'b01;
    localparam logic [1:0] OpMthi = 2'b10;
    localparam logic [1:0] OpMtlo = 2'b11;

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StCommit, StFault} state_e;

    state_e        state_q, state_d;
    logic          sel_div_q, sel_div_d;
    logic          zero_fault_q, zero_fault_d;
    logic          mt_done_q, mt_done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic [31:0]   div_a_q, div_a_d, div_b_q, div_b_d;
    logic          unit_done;

    // Only the selected unit's done is watched.
    assign unit_done = sel_div_q ? DivDone : MultDone;

    always_comb begin
        state_d      = state_q;
        sel_div_d    = sel_div_q;
        zero_fault_d = zero_fault_q;
        mt_done_d    = 1'b0;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    unique case (Op)
                        OpMthi: begin
                            hi_d      = A;
                            mt_done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d      = A;
                            mt_done_d = 1'b1;
                        end
                        OpDiv: begin
                            if (B == 32'd0) begin
                                zero_fault_d = 1'b1;
                                state_d      = StFault;
                            end else begin
                                div_a_d   = A;
                                div_b_d   = B;
                                sel_div_d = 1'b1;
                                state_d   = StLaunch;
                            end
                        end
                        OpMult: begin
                            mult_a_d  = A;
                            mult_b_d  = B;
                            sel_div_d = 1'b0;
                            state_d   = StLaunch;
                        end
                    endcase
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (unit_done) begin
                    hi_d    = sel_div_q ? DivHigh : MultHigh;
                    lo_d    = sel_div_q ? DivLow : MultLow;
                    state_d = StCommit;
                end else if (cnt_q == CntMax) begin
                    zero_fault_d = 1'b0;
                    state_d      = StFault;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCommit: state_d = StIdle;
            StFault:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= StIdle;
            sel_div_q    <= 1'b0;
            zero_fault_q <= 1'b0;
            mt_done_q    <= 1'b0;
            cnt_q        <= '0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            mult_a_q     <= 32'd0;
            mult_b_q     <= 32'd0;
            div_a_q      <= 32'd0;
            div_b_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            sel_div_q    <= sel_div_d;
            zero_fault_q <= zero_fault_d;
            mt_done_q    <= mt_done_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
        end
    end

    assign MultStart = (state_q == StLaunch) && !sel_div_q;
    assign DivStart  = (state_q == StLaunch) && sel_div_q;
    assign Busy      = (state_q != StIdle);
    // MTHI/MTLO complete without leaving IDLE, so their Done comes from a registered flag.
    assign Done      = (state_q == StCommit) || mt_done_q;
    assign DivZero   = (state_q == StFault) && zero_fault_q;
    assign Timeout   = (state_q == StFault) && !zero_fault_q;
    assign MultA     = mult_a_q;
    assign MultB     = mult_b_q;
    assign DivA      = div_a_q;
    assign DivB      = div_b_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: expected HI/LO queued at issue, popped on each Done,
// with simple latency-programmable multiplier and divider models.
module tb_muldiv_controller;

    logic        Clock = 1'b0;
    logic        Reset, Start;
    logic [1:0]  Op;
    logic [31:0] A, B;
    logic        MultStart, DivStart, Busy, Done, DivZero, Timeout;
    logic [31:0] MultA, MultB, DivA, DivB, HI, LO;
    logic        MultDone = 1'b0, DivDone = 1'b0;
    logic [31:0] MultHigh = 32'd0, MultLow = 32'd0, DivHigh = 32'd0, DivLow = 32'd0;

    muldiv_controller #(.TIMEOUT(48)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .MultStart(MultStart), .MultA(MultA), .MultB(MultB), .MultDone(MultDone),
        .MultHigh(MultHigh), .MultLow(MultLow),
        .DivStart(DivStart), .DivA(DivA), .DivB(DivB), .DivDone(DivDone),
        .DivHigh(DivHigh), .DivLow(DivLow),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Timeout(Timeout), .HI(HI), .LO(LO)
    );

    always #5 Clock = ~Clock;

    // Unit models: answer m_lat/d_lat edges after sampling their start pulse.
    int          m_lat = 0, d_lat = 0, m_cnt = 0, d_cnt = 0;
    logic [31:0] m_hi = 0, m_lo = 0, d_hi = 0, d_lo = 0;

    always @(posedge Clock) begin
        MultDone <= 1'b0;
        DivDone  <= 1'b0;
        if (MultStart) m_cnt <= 1;
        else if (m_cnt != 0) begin
            if (m_cnt == m_lat) begin
                MultDone <= 1'b1; MultHigh <= m_hi; MultLow <= m_lo; m_cnt <= 0;
            end else m_cnt <= m_cnt + 1;
        end
        if (DivStart) d_cnt <= 1;
        else if (d_cnt != 0) begin
            if (d_cnt == d_lat) begin
                DivDone <= 1'b1; DivHigh <= d_hi; DivLow <= d_lo; d_cnt <= 0;
            end else d_cnt <= d_cnt + 1;
        end
    end

    int          errors = 0, checks = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_hi = 0, exp_lo = 0;
    int          n_mstart, n_dstart, n_done, n_dz, n_to, n_busy;
    int          mstart_cyc, done_cyc, dz_cyc, to_cyc, idle_cyc;

    // Issue one op at edge 0 and observe cycles 1.. until Busy is low.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int budget);
        logic [63:0] e;
        bit fin;
        n_mstart = 0; n_dstart = 0; n_done = 0; n_dz = 0; n_to = 0; n_busy = 0;
        mstart_cyc = -1; done_cyc = -1; dz_cyc = -1; to_cyc = -1; idle_cyc = -1;
        fin = 1'b0;
        @(negedge Clock);
        Start = 1'b1; Op = op; A = a; B = b;
        for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
            @(negedge Clock);
            Start = 1'b0;
            if (MultStart) begin n_mstart++; mstart_cyc = cyc; end
            if (DivStart) n_dstart++;
            if (DivZero) begin n_dz++; dz_cyc = cyc; end
            if (Timeout) begin n_to++; to_cyc = cyc; end
            if (Busy) n_busy++;
            if (Done) begin
                n_done++; done_cyc = cyc; checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: Done at cycle %0d, HI=%h LO=%h", cyc, HI, LO);
                end else begin
                    e = sb.pop_front();
                    if ({HI, LO} !== e) begin
                        errors++;
                        $display("FAIL sb_hilo: got %h want %h", {HI, LO}, e);
                    end
                end
            end
            if (!Busy) begin fin = 1'b1; idle_cyc = cyc; end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL op_bound: Busy still high after %0d cycles, want low", budget);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({Busy, Done, DivZero, Timeout, MultStart, DivStart} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {Busy, Done, DivZero, Timeout, MultStart, DivStart});
        end
        checks++;
        if ({HI, LO, MultA, MultB, DivA, DivB} !== 192'd0) begin
            errors++;
            $display("FAIL reset_regs: HI=%h LO=%h MA=%h MB=%h DA=%h DB=%h want all 0",
                     HI, LO, MultA, MultB, DivA, DivB);
        end
        Reset = 1'b0;
    endtask

    task automatic test_mult();
        m_lat = 33; m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;
        exp_hi = m_hi; exp_lo = m_lo;
        sb.push_back({exp_hi, exp_lo});
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 80);
        checks++;
        if (n_mstart !== 1 || mstart_cyc !== 1) begin
            errors++;
            $display("FAIL mult_start: pulses=%0d at %0d, want 1 at 1", n_mstart, mstart_cyc);
        end
        checks++;
        if (n_dstart !== 0) begin
            errors++; $display("FAIL mult_divstart: got %0d want 0", n_dstart);
        end
        checks++;
        if (n_done !== 1 || done_cyc !== 36) begin
            errors++;
            $display("FAIL mult_done: count=%0d at %0d, want 1 at 36", n_done, done_cyc);
        end
        checks++;
        if (idle_cyc !== done_cyc + 1) begin
            errors++; $display("FAIL mult_busy_drop: got %0d want %0d", idle_cyc, done_cyc + 1);
        end
        checks++;
        if (MultA !== 32'd7 || MultB !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL mult_operands: got %h %h want 7 fffffffd", MultA, MultB);
        end
    endtask

    task automatic test_div();
        d_lat = 10; d_hi = 32'd2; d_lo = 32'd14;
        exp_hi = 32'd2; exp_lo = 32'd14;
        sb.push_back({exp_hi, exp_lo});
        run_op(2'b01, 32'd100, 32'd7, 80);
        checks++;
        if (n_mstart !== 0 || n_dstart !== 1) begin
            errors++;
            $display("FAIL div_starts: mult=%0d div=%0d want 0 1", n_mstart, n_dstart);
        end
        checks++;
        if (n_done !== 1 || done_cyc !== 13) begin
            errors++;
            $display("FAIL div_done: count=%0d at %0d, want 1 at 13", n_done, done_cyc);
        end
        checks++;
        if (DivA !== 32'd100 || DivB !== 32'd7 || MultA !== 32'd7) begin
            errors++;
            $display("FAIL div_operands: DA=%h DB=%h MA=%h want 64 7 7", DivA, DivB, MultA);
        end
    endtask

    task automatic test_divzero();
        run_op(2'b01, 32'd5, 32'd0, 10);
        checks++;
        if (n_dz !== 1 || dz_cyc !== 1) begin
            errors++; $display("FAIL dz_pulse: count=%0d at %0d want 1 at 1", n_dz, dz_cyc);
        end
        checks++;
        if (n_dstart !== 0 || n_done !== 0 || n_to !== 0) begin
            errors++;
            $display("FAIL dz_side: dstart=%0d done=%0d to=%0d want 0", n_dstart, n_done, n_to);
        end
        checks++;
        if (n_busy !== 1) begin
            errors++; $display("FAIL dz_busy: got %0d cycles want 1", n_busy);
        end
        checks++;
        if (HI !== exp_hi || LO !== exp_lo || DivA !== 32'd100) begin
            errors++;
            $display("FAIL dz_hold: HI=%h LO=%h DA=%h want %h %h 64", HI, LO, DivA, exp_hi, exp_lo);
        end
    endtask

    task automatic test_timeout();
        bit mdone_seen;
        int late_done;
        m_lat = 60; m_hi = 32'hAAAA_AAAA; m_lo = 32'h5555_5555;
        run_op(2'b00, 32'd3, 32'd4, 80);
        checks++;
        if (n_to !== 1 || to_cyc !== 50) begin
            errors++; $display("FAIL to_pulse: count=%0d at %0d want 1 at 50", n_to, to_cyc);
        end
        checks++;
        if (n_busy !== 50 || n_done !== 0 || n_dz !== 0) begin
            errors++;
            $display("FAIL to_side: busy=%0d done=%0d dz=%0d want 50 0 0", n_busy, n_done, n_dz);
        end
        mdone_seen = 1'b0; late_done = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge Clock);
            if (MultDone) mdone_seen = 1'b1;
            if (Done || Busy) late_done++;
        end
        checks++;
        if (!mdone_seen || late_done !== 0) begin
            errors++;
            $display("FAIL to_late_done: seen=%0d reacted=%0d want 1 0", mdone_seen, late_done);
        end
        checks++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            errors++; $display("FAIL to_hold: HI=%h LO=%h want %h %h", HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        int dones;
        dones = 0;
        @(negedge Clock);
        Start = 1'b1; Op = 2'b10; A = 32'hDEAD_BEEF;
        exp_hi = 32'hDEAD_BEEF;
        sb.push_back({exp_hi, exp_lo});
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge Clock);
            checks++;
            if (Busy !== 1'b0) begin
                errors++; $display("FAIL b2b_busy: cycle %0d got %b want 0", cyc, Busy);
            end
            if (Done) begin
                dones++; checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_done: cycle %0d, want no Done", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({HI, LO} !== e) begin
                        errors++; $display("FAIL b2b_hilo: got %h want %h", {HI, LO}, e);
                    end
                end
            end
            if (cyc == 1) begin
                Op = 2'b11; A = 32'h1234_5678;
                exp_lo = 32'h1234_5678;
                sb.push_back({exp_hi, exp_lo});
            end else Start = 1'b0;
        end
        checks++;
        if (dones !== 2 || HI !== 32'hDEAD_BEEF || LO !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_final: dones=%0d HI=%h LO=%h want 2 deadbeef 12345678", dones, HI, LO);
        end
    endtask

    task automatic test_reset_mid_op();
        bit mdone_seen;
        int dones, dstarts, mstarts, busy_after;
        mdone_seen = 1'b0; dones = 0; dstarts = 0; mstarts = 0; busy_after = 0;
        m_lat = 20; m_hi = 32'h0BAD_0BAD; m_lo = 32'h0BAD_0BAD;
        @(negedge Clock);
        Start = 1'b1; Op = 2'b00; A = 32'd11; B = 32'd22;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge Clock);
            if (Done) dones++;
            if (DivStart) dstarts++;
            if (MultStart) mstarts++;
            if (MultDone) mdone_seen = 1'b1;
            if (cyc >= 6 && Busy) busy_after++;
            if (cyc == 1) begin Op = 2'b01; A = 32'd9; B = 32'd3; end
            if (cyc == 3) Start = 1'b0;
            if (cyc == 5) Reset = 1'b1;
            if (cyc == 6) Reset = 1'b0;
        end
        exp_hi = 32'd0; exp_lo = 32'd0;
        checks++;
        if (dones !== 0 || dstarts !== 0 || mstarts !== 1) begin
            errors++;
            $display("FAIL rst_mid_pulses: done=%0d dstart=%0d mstart=%0d want 0 0 1",
                     dones, dstarts, mstarts);
        end
        checks++;
        if (busy_after !== 0 || !mdone_seen) begin
            errors++;
            $display("FAIL rst_mid_idle: busy=%0d mdone_seen=%0d want 0 1", busy_after, mdone_seen);
        end
        checks++;
        if (HI !== exp_hi || LO !== exp_lo || MultA !== 32'd0) begin
            errors++; $display("FAIL rst_mid_regs: HI=%h LO=%h MA=%h want 0", HI, LO, MultA);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
